// File: rtl/cache_pkg.sv
// Shared constants, types and helpers for the cache refill/writeback path.
package cache_pkg;

  localparam int ADDR_W      = 32;
  localparam int LINE_W      = 128;
  localparam int BEAT_W      = 32;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int OFFS_W      = 4;
  localparam int IDX_W       = $clog2(BEATS);
  localparam int CNT_W       = $clog2(BEATS + 1);
  localparam int LINE_ADDR_W = ADDR_W - OFFS_W;

  localparam logic [CNT_W-1:0] BEATS_CNT = CNT_W'(BEATS);

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } refill_state_e;

  // Byte address of beat idx within the line: line address, beat index, word offset zero.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [LINE_ADDR_W-1:0] line_addr,
                                                  input logic [IDX_W-1:0]       idx);
    return {line_addr, idx, {(OFFS_W - IDX_W){1'b0}}};
  endfunction

endpackage

// File: rtl/cache_line_buf.sv
// One cache line of storage with whole-line load and beat-granular write/read ports.
module cache_line_buf
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  line_t            load_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  beat_t            wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output beat_t            rd_data,
  output line_t            line_out
);

  line_t line_q, line_d;

  // Next line contents: a whole-line load wins over a single-beat write.
  always_comb begin
    line_d = line_q;
    if (load_en) begin
      line_d = load_data;
    end else if (wr_en) begin
      line_d[wr_idx*BEAT_W +: BEAT_W] = wr_data;
    end
  end

  // Line storage register, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign rd_data  = line_q[rd_idx*BEAT_W +: BEAT_W];
  assign line_out = line_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Splits a line request into word beats on the downstream bus, gathers the
// in-order beat responses and returns a single line response upstream.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [LINE_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BEAT_W-1:0] bus_wdata,
  input  logic              bus_rvalid,
  input  logic [BEAT_W-1:0] bus_rdata,
  input  logic              bus_rerr
);

  refill_state_e          state_q, state_d;
  logic                   we_q, we_d;
  logic [LINE_ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]       resp_cnt_q, resp_cnt_d;
  logic                   err_q, err_d;

  logic                   beat_acc;
  logic                   resp_acc;
  logic [CNT_W-1:0]       issued_now;
  logic                   buf_load;
  logic                   buf_wr_en;
  beat_t                  buf_rd_data;
  line_t                  buf_line;
  logic                   addr_offs_unused;

  // The byte offset inside the line carries no information for line requests.
  assign addr_offs_unused = ^req_addr[OFFS_W-1:0];

  assign req_ready  = (state_q == IDLE);
  assign bus_valid  = (state_q == BUSY) && (issue_cnt_q < BEATS_CNT);
  assign bus_we     = bus_valid && we_q;
  assign bus_addr   = bus_valid ? beat_addr(line_addr_q, issue_cnt_q[IDX_W-1:0]) : '0;
  assign bus_wdata  = bus_valid ? buf_rd_data : '0;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = (rsp_valid && !we_q) ? buf_line : '0;
  assign rsp_err    = rsp_valid && err_q;

  // A response is only genuine if it matches a beat already issued, counting
  // a beat accepted in this very cycle.
  assign beat_acc   = bus_valid && bus_ready;
  assign issued_now = issue_cnt_q + CNT_W'(beat_acc);
  assign resp_acc   = (state_q == BUSY) && bus_rvalid && (resp_cnt_q < issued_now);

  cache_line_buf u_line_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (buf_load),
    .load_data (req_wdata),
    .wr_en     (buf_wr_en),
    .wr_idx    (resp_cnt_q[IDX_W-1:0]),
    .wr_data   (bus_rdata),
    .rd_idx    (issue_cnt_q[IDX_W-1:0]),
    .rd_data   (buf_rd_data),
    .line_out  (buf_line)
  );

  // Next-state logic: accept in IDLE, issue and collect beats in BUSY, hold the line response in RESP.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    line_addr_d = line_addr_q;
    issue_cnt_d = issue_cnt_q;
    resp_cnt_d  = resp_cnt_q;
    err_d       = err_q;
    buf_load    = 1'b0;
    buf_wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          line_addr_d = req_addr[ADDR_W-1:OFFS_W];
          issue_cnt_d = '0;
          resp_cnt_d  = '0;
          err_d       = 1'b0;
          buf_load    = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        issue_cnt_d = issued_now;
        if (resp_acc) begin
          buf_wr_en  = !we_q;
          err_d      = err_q | bus_rerr;
          resp_cnt_d = resp_cnt_q + CNT_W'(1);
        end
        if (resp_cnt_d == BEATS_CNT) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers with asynchronous return to the idle reset state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      line_addr_q <= '0;
      issue_cnt_q <= '0;
      resp_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      line_addr_q <= line_addr_d;
      issue_cnt_q <= issue_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule
